// File: rtl/buzzer_tone_arbiter_pkg.sv
// Shared types and constants for the buzzer tone arbiter.
//  - state_t      : arbiter FSM states
//  - REQ_*        : requester indices (bit position in REQ/GNT/PEND)
//  - HALF_P*_DEF  : default note half-periods at 50 MHz
//  - top_req()    : fixed-priority encoder, bit 2 highest
package buzzer_pkg;

   typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

   localparam int NUM_REQ  = 3;
   localparam int REQ_HIT  = 0;
   localparam int REQ_DIR  = 1;
   localparam int REQ_WRAP = 2;

   localparam int HALF_P0_DEF = 56_818;     // LA 440 Hz
   localparam int HALF_P1_DEF = 95_555;     // DO 261.63 Hz
   localparam int HALF_P2_DEF = 37_921;     // MI 659.25 Hz
   localparam int DUR_CYC_DEF = 12_500_000; // 250 ms
   localparam int GAP_CYC_DEF = 2_500_000;  // 50 ms

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // Index of the highest set bit; 0 when nothing is set (callers gate on |r).
   function automatic logic [1:0] top_req(input logic [NUM_REQ-1:0] r);
      if (r[REQ_WRAP])     return 2'(REQ_WRAP);
      else if (r[REQ_DIR]) return 2'(REQ_DIR);
      else                 return 2'(REQ_HIT);
   endfunction

endpackage

// File: rtl/buzzer_tone_arbiter_if.sv
// Requester/buzzer bus for the tone arbiter.
//  EN        : 1 = buzzer enabled, 0 = mute and flush
//  REQ[2:0]  : one-cycle request pulses, bit 2 highest priority
//  GNT[2:0]  : one-cycle one-hot grant pulse
//  ACTIVE_ID : requester currently playing
//  BUSY      : high in PLAY or GAP
//  BUZZER    : square-wave drive to the passive buzzer
// master = event logic side, slave = arbiter side.
interface buzzer_tone_arbiter_if;
   logic       EN;
   logic [2:0] REQ;
   logic [2:0] GNT;
   logic [1:0] ACTIVE_ID;
   logic       BUSY;
   logic       BUZZER;

   modport master (output EN, REQ, input GNT, ACTIVE_ID, BUSY, BUZZER);
   modport slave  (input EN, REQ, output GNT, ACTIVE_ID, BUSY, BUZZER);
endinterface

// File: rtl/buzzer_tone_arbiter_tone_divider.sv
// Square-wave generator: toggles WAVE every HALF_P cycles while RUN is high.
// CLR has priority and forces counter and WAVE to 0 (phase restart, output low).
//  CLK, RST_N : clock, async active-low reset
//  CLR        : synchronous clear
//  RUN        : count enable
//  HALF_P     : half-period in cycles (>= 1)
//  WAVE       : registered square wave
module tone_divider #(
   parameter int W = 18
) (
   input  logic         CLK,
   input  logic         RST_N,
   input  logic         CLR,
   input  logic         RUN,
   input  logic [W-1:0] HALF_P,
   output logic         WAVE
);

   logic [W-1:0] cnt;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         cnt  <= '0;
         WAVE <= 1'b0;
      end else if (CLR) begin
         cnt  <= '0;
         WAVE <= 1'b0;
      end else if (RUN) begin
         if (cnt == HALF_P - W'(1)) begin
            cnt  <= '0;
            WAVE <= ~WAVE;
         end else begin
            cnt <= cnt + W'(1);
         end
      end
   end

endmodule

// File: rtl/buzzer_tone_arbiter.sv
// Fixed-priority arbiter sharing one passive buzzer between three tone requesters.
// Winner plays its note for DUR_CYC cycles, then a GAP_CYC silent gap; lower-priority
// requests arriving meanwhile are held one-deep in PEND, higher ones preempt.
//  CLK, RST_N : clock, async active-low reset
//  bus        : slave side of buzzer_tone_arbiter_if (EN, REQ in; GNT, ACTIVE_ID, BUSY, BUZZER out)
module buzzer_tone_arbiter
   import buzzer_pkg::*;
#(
   parameter int HALF_P0 = HALF_P0_DEF,
   parameter int HALF_P1 = HALF_P1_DEF,
   parameter int HALF_P2 = HALF_P2_DEF,
   parameter int DUR_CYC = DUR_CYC_DEF,
   parameter int GAP_CYC = GAP_CYC_DEF
) (
   input  logic CLK,
   input  logic RST_N,
   buzzer_tone_arbiter_if.slave bus
);

   localparam int TW = $clog2(max2(HALF_P0, max2(HALF_P1, HALF_P2))) + 1;
   localparam int CW = $clog2(max2(DUR_CYC, GAP_CYC)) + 1;

   state_t              state;
   logic [NUM_REQ-1:0]  pend, gnt;
   logic [1:0]          active_id;
   logic                busy;
   logic [CW-1:0]       cnt;      // shared duration / gap counter
   logic                wave;
   logic [TW-1:0]       half_sel;

   logic [NUM_REQ-1:0]  req_all;
   logic [1:0]          win_all, win_req;
   logic [NUM_REQ-1:0]  oh_all, oh_req;
   logic                preempt, rearm, play_end, tone_clr;

   assign req_all = pend | bus.REQ;
   assign win_all = top_req(req_all);
   assign win_req = top_req(bus.REQ);
   assign oh_all  = NUM_REQ'(1) << win_all;
   assign oh_req  = NUM_REQ'(1) << win_req;

   // Pending bits are always below ACTIVE_ID during PLAY, so only live REQ can
   // preempt or re-arm.
   assign preempt  = (state == PLAY) && (|bus.REQ) && (win_req > active_id);
   assign rearm    = (state == PLAY) && (|bus.REQ) && (win_req == active_id);
   assign play_end = (state == PLAY) && !preempt && !rearm && (cnt == CW'(DUR_CYC - 1));

   // Any grant, note end, mute or non-PLAY state forces the wave low and restarts its phase.
   assign tone_clr = !bus.EN || (state != PLAY) || preempt || play_end;

   always_comb begin
      half_sel = TW'(HALF_P0);
      case (active_id)
         2'(REQ_DIR):  half_sel = TW'(HALF_P1);
         2'(REQ_WRAP): half_sel = TW'(HALF_P2);
         default:      half_sel = TW'(HALF_P0);
      endcase
   end

   tone_divider #(.W(TW)) u_tone (
      .CLK    (CLK),
      .RST_N  (RST_N),
      .CLR    (tone_clr),
      .RUN    (state == PLAY),
      .HALF_P (half_sel),
      .WAVE   (wave)
   );

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state     <= IDLE;
         pend      <= '0;
         gnt       <= '0;
         active_id <= '0;
         busy      <= 1'b0;
         cnt       <= '0;
      end else begin
         gnt <= '0;
         if (!bus.EN) begin
            state <= IDLE;
            pend  <= '0;
            busy  <= 1'b0;
            cnt   <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (|req_all) begin
                     state     <= PLAY;
                     busy      <= 1'b1;
                     gnt       <= oh_all;
                     active_id <= win_all;
                     pend      <= req_all & ~oh_all;
                     cnt       <= '0;
                  end
               end
               PLAY: begin
                  if (preempt) begin
                     // Preempted requester is dropped; other live bits still pend.
                     gnt       <= oh_req;
                     active_id <= win_req;
                     pend      <= pend | (bus.REQ & ~oh_req);
                     cnt       <= '0;
                  end else if (rearm) begin
                     pend <= pend | (bus.REQ & ~oh_req);
                     cnt  <= '0;
                  end else begin
                     pend <= pend | bus.REQ;
                     if (play_end) begin
                        state <= GAP;
                        cnt   <= '0;
                     end else begin
                        cnt <= cnt + CW'(1);
                     end
                  end
               end
               GAP: begin
                  pend <= pend | bus.REQ;
                  if (cnt == CW'(GAP_CYC - 1)) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                     cnt   <= '0;
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign bus.GNT       = gnt;
   assign bus.ACTIVE_ID = active_id;
   assign bus.BUSY      = busy;
   assign bus.BUZZER    = wave;

endmodule

// File: tb/tb_buzzer_tone_arbiter.sv
// Directed bench for buzzer_tone_arbiter with short sim parameters
// (HALF_P0=4, HALF_P1=6, HALF_P2=3, DUR_CYC=40, GAP_CYC=5).
// Inputs change 1 ns after the rising edge; outputs are sampled there too.
// En = grant edge of the note under test.
module tb_buzzer_tone_arbiter;

   logic CLK = 1'b0;
   logic RST_N;
   int   passes = 0;
   int   total  = 0;

   buzzer_tone_arbiter_if bus ();

   buzzer_tone_arbiter #(
      .HALF_P0 (4),
      .HALF_P1 (6),
      .HALF_P2 (3),
      .DUR_CYC (40),
      .GAP_CYC (5)
   ) dut (
      .CLK   (CLK),
      .RST_N (RST_N),
      .bus   (bus)
   );

   always #5 CLK = ~CLK;

   task automatic step(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   // Pulse REQ for one cycle; on return we sit just after the edge that sampled it.
   task automatic pulse(input logic [2:0] r);
      bus.REQ = r;
      step();
      bus.REQ = 3'b000;
   endtask

   initial begin
      RST_N   = 1'b0;
      bus.EN  = 1'b1;
      bus.REQ = 3'b000;
      #12;
      chk("rst_buzzer", 32'(bus.BUZZER), 0);
      chk("rst_busy",   32'(bus.BUSY), 0);
      chk("rst_gnt",    32'(bus.GNT), 0);
      chk("rst_id",     32'(bus.ACTIVE_ID), 0);
      RST_N = 1'b1;
      step(2);
      chk("idle_busy", 32'(bus.BUSY), 0);

      // Single hit
      pulse(3'b001);                                   // E0
      chk("hit_gnt",  32'(bus.GNT), 32'b001);
      chk("hit_busy", 32'(bus.BUSY), 1);
      chk("hit_id",   32'(bus.ACTIVE_ID), 0);
      chk("hit_bz0",  32'(bus.BUZZER), 0);
      step();                                          // E1
      chk("hit_gnt_pulse", 32'(bus.GNT), 0);
      step(2);                                         // E3
      chk("hit_bz_e3", 32'(bus.BUZZER), 0);
      step();                                          // E4
      chk("hit_bz_e4", 32'(bus.BUZZER), 1);
      step(4);                                         // E8
      chk("hit_bz_e8", 32'(bus.BUZZER), 0);
      step(31);                                        // E39
      chk("hit_bz_e39",   32'(bus.BUZZER), 1);
      chk("hit_busy_e39", 32'(bus.BUSY), 1);
      step();                                          // E40
      chk("hit_bz_gap",   32'(bus.BUZZER), 0);
      chk("hit_busy_gap", 32'(bus.BUSY), 1);
      step(4);                                         // E44
      chk("hit_busy_e44", 32'(bus.BUSY), 1);
      step();                                          // E45
      chk("hit_busy_e45", 32'(bus.BUSY), 0);
      step();                                          // E46
      chk("hit_no_replay", 32'(bus.GNT), 0);

      // Preempt hit by wrap while buzzer is high
      pulse(3'b001);                                   // E0
      step(5);                                         // E5
      chk("pre_bz_hi", 32'(bus.BUZZER), 1);
      pulse(3'b100);                                   // E6 = new E0
      chk("pre_gnt", 32'(bus.GNT), 32'b100);
      chk("pre_id",  32'(bus.ACTIVE_ID), 2);
      chk("pre_bz",  32'(bus.BUZZER), 0);
      step(3);
      chk("pre_bz_t3", 32'(bus.BUZZER), 1);
      step(3);
      chk("pre_bz_t6", 32'(bus.BUZZER), 0);
      step(33);                                        // +39
      chk("pre_busy_39", 32'(bus.BUSY), 1);
      step();                                          // +40
      chk("pre_bz_gap", 32'(bus.BUZZER), 0);
      step(5);                                         // +45
      chk("pre_idle", 32'(bus.BUSY), 0);
      step(3);
      chk("pre_no_hit_busy", 32'(bus.BUSY), 0);
      chk("pre_no_hit_gnt",  32'(bus.GNT), 0);

      // Pending: dir playing, hit arrives
      pulse(3'b010);                                   // E0
      chk("pend_gnt_dir", 32'(bus.GNT), 32'b010);
      step(4);
      pulse(3'b001);                                   // E5
      chk("pend_no_gnt", 32'(bus.GNT), 0);
      chk("pend_id",     32'(bus.ACTIVE_ID), 1);
      step(40);                                        // E45
      chk("pend_idle_gap", 32'(bus.BUSY), 0);
      step();                                          // E46
      chk("pend_gnt_hit", 32'(bus.GNT), 32'b001);
      chk("pend_id_hit",  32'(bus.ACTIVE_ID), 0);
      step(45);
      chk("pend_done", 32'(bus.BUSY), 0);

      // Simultaneous requests
      pulse(3'b111);                                   // E0
      chk("sim_gnt2", 32'(bus.GNT), 32'b100);
      step(45);
      chk("sim_gap_gnt", 32'(bus.GNT), 0);
      step();
      chk("sim_gnt1", 32'(bus.GNT), 32'b010);
      step(46);
      chk("sim_gnt0", 32'(bus.GNT), 32'b001);
      step(45);
      chk("sim_end_busy", 32'(bus.BUSY), 0);
      step();
      chk("sim_end_gnt", 32'(bus.GNT), 0);

      // Re-arm: same requester mid-note extends duration, no grant
      pulse(3'b001);                                   // E0
      step(29);
      pulse(3'b001);                                   // E30
      chk("rearm_no_gnt", 32'(bus.GNT), 0);
      step(39);                                        // E69
      chk("rearm_busy", 32'(bus.BUSY), 1);
      chk("rearm_bz",   32'(bus.BUZZER), 1);
      step();                                          // E70
      chk("rearm_gap_bz", 32'(bus.BUZZER), 0);
      step(5);
      chk("rearm_done", 32'(bus.BUSY), 0);

      // Mute with wrap playing and hit+dir pending
      pulse(3'b100);                                   // E0
      pulse(3'b011);                                   // E1
      step(2);                                         // E3
      chk("mute_bz_hi", 32'(bus.BUZZER), 1);
      bus.EN = 1'b0;
      step();
      chk("mute_bz",   32'(bus.BUZZER), 0);
      chk("mute_busy", 32'(bus.BUSY), 0);
      pulse(3'b001);
      chk("mute_req_ign", 32'(bus.GNT), 0);
      bus.EN = 1'b1;
      step(3);
      chk("mute_resume_busy", 32'(bus.BUSY), 0);
      chk("mute_resume_gnt",  32'(bus.GNT), 0);

      // Async reset mid-PLAY
      pulse(3'b001);                                   // E0
      step(4);                                         // E4
      chk("rp_bz_hi", 32'(bus.BUZZER), 1);
      #2;
      RST_N = 1'b0;
      #0;
      #1;
      chk("rp_bz",   32'(bus.BUZZER), 0);
      chk("rp_busy", 32'(bus.BUSY), 0);
      chk("rp_gnt",  32'(bus.GNT), 0);
      RST_N = 1'b1;
      step(3);
      chk("rp_idle_busy", 32'(bus.BUSY), 0);
      chk("rp_idle_gnt",  32'(bus.GNT), 0);

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
